// File: rtl/bl_pkg.sv
// Shared definitions for the backlight zone SPI transmitter.
// Holds the frame geometry constants, the TX state encoding and the CRC-8
// update step (poly 0x07, init 0x00, MSB first, no reflection, no final XOR).
package bl_pkg;

  localparam int         ZONES  = 360;
  localparam int         DW     = 8;
  localparam logic [7:0] HEADER = 8'hA5;
  localparam int         AW     = $clog2(ZONES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CRC  = 3'd3,
    END  = 3'd4
  } tx_state_t;

  // One byte of CRC-8 advance: fold the byte in, then eight polynomial steps.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/bl_zone_spi_tx_if.sv
// Zone stream bundle from the backlight extractor.
//   flag_done        zone-complete strobe (may be held high several cycles)
//   buf_360_flatted  zone value, valid while flag_done is high
//   r_Vsync_0        frame sync, active-high
// master: extractor side (drives), slave: transmitter side (samples).
interface bl_zone_spi_tx_if;
  import bl_pkg::*;

  logic          flag_done;
  logic [DW-1:0] buf_360_flatted;
  logic          r_Vsync_0;

  modport master (output flag_done, buf_360_flatted, r_Vsync_0);
  modport slave  (input  flag_done, buf_360_flatted, r_Vsync_0);
endinterface

// File: rtl/bl_zone_ram.sv
// Ping-pong zone store: 2*ZONES x DW simple dual-port RAM with a registered
// read port. Address MSB selects the bank, the low bits the zone index.
//   clk    clock          we/waddr/wdata  write port
//   raddr  read address   rdata           read data, one cycle after raddr
module bl_zone_ram
  import bl_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdata
);

  localparam int IW = $clog2(2 * ZONES);

  logic [DW-1:0] mem_r [0:2*ZONES-1];

  // Banks are packed back to back, so bank 1 starts at ZONES rather than at 2**AW.
  function automatic logic [IW-1:0] phys(input logic [AW:0] a);
    return a[AW] ? (IW'(ZONES) + IW'(a[AW-1:0])) : IW'(a[AW-1:0]);
  endfunction

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[phys(waddr)] <= wdata;
    end
    rdata <= mem_r[phys(raddr)];
  end

endmodule

// File: rtl/bl_zone_spi_tx.sv
// Captures one backlight byte per zone strobe into a ping-pong RAM and, at each
// complete frame boundary, swaps banks and sends HEADER + ZONES bytes over a
// mode-0 SPI link (MSB first). Optional trailing CRC-8 when BL_CRC8_EN is defined.
//   i_pix_clk, rst     clock, async active-high reset
//   zin                zone stream (bl_zone_spi_tx_if.slave)
//   o_spi_sclk/mosi/cs_n  serial link
//   o_busy             frame on the wire
//   o_frame_drop       1-cycle pulse: short frame or overrun, nothing sent
//   o_frame_cnt        frames sent (wraps)
module bl_zone_spi_tx
  import bl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   i_pix_clk,
  input  logic                   rst,
  bl_zone_spi_tx_if.slave        zin,
  output logic                   o_spi_sclk,
  output logic                   o_spi_mosi,
  output logic                   o_spi_cs_n,
  output logic                   o_busy,
  output logic                   o_frame_drop,
  output logic [15:0]            o_frame_cnt
);

  localparam int                DIVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0]   DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [AW-1:0]     ZONES_W  = AW'(ZONES);

  // capture side
  logic          flag_d_r, vsync_d_r, wr_bank_r, start_r, drop_r;
  logic [AW-1:0] wr_cnt_r;
  logic          flag_edge_s, vsync_edge_s, full_s, swap_s, drop_s, we_s, wr_bank_s;
  logic [AW-1:0] wr_cnt_s, wr_addr_s;

  // transmit side
  tx_state_t     state_r, state_s;
  logic [DIVW-1:0] div_r, div_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    sh_r, sh_s;
  logic [AW-1:0] rd_addr_r, rd_addr_s, rd_idx_s;
  logic          sclk_r, sclk_s, cs_n_r, cs_n_s, busy_r, busy_s;
  logic [15:0]   frame_cnt_r, frame_cnt_s;
  logic [DW-1:0] rdata_s;
`ifdef BL_CRC8_EN
  logic [7:0]    crc_r, crc_s;
`endif

  // Edge detection, frame-boundary decision and write addressing. The vsync
  // decision is taken first so a coinciding strobe lands at index 0 of the new frame.
  always_comb begin
    flag_edge_s  = zin.flag_done & ~flag_d_r;
    vsync_edge_s = zin.r_Vsync_0 & ~vsync_d_r;
    full_s       = (wr_cnt_r == ZONES_W);
    swap_s       = vsync_edge_s & full_s & ~busy_r & ~start_r;
    drop_s       = vsync_edge_s & ~swap_s;
    we_s         = flag_edge_s & (vsync_edge_s | ~full_s);
    wr_bank_s    = swap_s ? ~wr_bank_r : wr_bank_r;
    wr_addr_s    = vsync_edge_s ? AW'(0) : wr_cnt_r;
    wr_cnt_s     = wr_cnt_r;
    if (vsync_edge_s) begin
      wr_cnt_s = we_s ? AW'(1) : AW'(0);
    end else if (we_s) begin
      wr_cnt_s = wr_cnt_r + AW'(1);
    end else begin
      wr_cnt_s = wr_cnt_r;
    end
  end

  // Capture-side registers.
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      flag_d_r  <= 1'b0;
      vsync_d_r <= 1'b0;
      wr_cnt_r  <= AW'(0);
      wr_bank_r <= 1'b0;
      start_r   <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      flag_d_r  <= zin.flag_done;
      vsync_d_r <= zin.r_Vsync_0;
      wr_cnt_r  <= wr_cnt_s;
      wr_bank_r <= wr_bank_s;
      start_r   <= swap_s;
      drop_r    <= drop_s;
    end
  end

  // rd_addr reaches ZONES after the last byte is loaded; keep the RAM address in range.
  assign rd_idx_s = (rd_addr_r < ZONES_W) ? rd_addr_r : AW'(0);

  bl_zone_ram u_ram (
    .clk   (i_pix_clk),
    .we    (we_s),
    .waddr ({wr_bank_s, wr_addr_s}),
    .wdata (zin.buf_360_flatted),
    .raddr ({~wr_bank_r, rd_idx_s}),
    .rdata (rdata_s)
  );

  // TX next-state and output computation. rd_addr is the next byte to load and
  // is stable for a whole byte, so the registered RAM output is ready at the byte boundary.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    bit_s       = bit_r;
    sh_s        = sh_r;
    rd_addr_s   = rd_addr_r;
    sclk_s      = sclk_r;
    cs_n_s      = cs_n_r;
    busy_s      = busy_r;
    frame_cnt_s = frame_cnt_r;
`ifdef BL_CRC8_EN
    crc_s       = crc_r;
`endif
    case (state_r)
      IDLE: begin
        sclk_s    = 1'b0;
        div_s     = DIVW'(0);
        bit_s     = 3'd0;
        rd_addr_s = AW'(0);
        if (start_r) begin
          state_s = HDR;
          cs_n_s  = 1'b0;
          busy_s  = 1'b1;
          sh_s    = HEADER;
`ifdef BL_CRC8_EN
          crc_s   = 8'h00;
`endif
        end else begin
          cs_n_s = 1'b1;
          busy_s = 1'b0;
          sh_s   = 8'h00;
        end
      end
      HDR, DATA, CRC: begin
        if (div_r != DIV_LAST) begin
          div_s = div_r + DIVW'(1);
        end else if (!sclk_r) begin
          div_s  = DIVW'(0);
          sclk_s = 1'b1;
        end else if (bit_r != 3'd7) begin
          div_s  = DIVW'(0);
          sclk_s = 1'b0;
          bit_s  = bit_r + 3'd1;
          sh_s   = {sh_r[6:0], 1'b0};
        end else begin
          div_s  = DIVW'(0);
          sclk_s = 1'b0;
          bit_s  = 3'd0;
          if (state_r == CRC || (state_r == DATA && rd_addr_r == ZONES_W)) begin
`ifdef BL_CRC8_EN
            if (state_r == DATA) begin
              state_s = CRC;
              sh_s    = crc_r;
            end else begin
              state_s = END;
              sh_s    = 8'h00;
            end
`else
            state_s = END;
            sh_s    = 8'h00;
`endif
          end else begin
            state_s   = DATA;
            sh_s      = rdata_s;
            rd_addr_s = rd_addr_r + AW'(1);
`ifdef BL_CRC8_EN
            crc_s     = crc8_next(crc_r, rdata_s);
`endif
          end
        end
      end
      END: begin
        if (div_r == DIV_LAST) begin
          div_s       = DIVW'(0);
          state_s     = IDLE;
          cs_n_s      = 1'b1;
          busy_s      = 1'b0;
          frame_cnt_s = frame_cnt_r + 16'd1;
        end else begin
          div_s = div_r + DIVW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cs_n_s  = 1'b1;
        busy_s  = 1'b0;
        sclk_s  = 1'b0;
        sh_s    = 8'h00;
      end
    endcase
  end

  // TX state and output registers.
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      div_r       <= DIVW'(0);
      bit_r       <= 3'd0;
      sh_r        <= 8'h00;
      rd_addr_r   <= AW'(0);
      sclk_r      <= 1'b0;
      cs_n_r      <= 1'b1;
      busy_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
`ifdef BL_CRC8_EN
      crc_r       <= 8'h00;
`endif
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      bit_r       <= bit_s;
      sh_r        <= sh_s;
      rd_addr_r   <= rd_addr_s;
      sclk_r      <= sclk_s;
      cs_n_r      <= cs_n_s;
      busy_r      <= busy_s;
      frame_cnt_r <= frame_cnt_s;
`ifdef BL_CRC8_EN
      crc_r       <= crc_s;
`endif
    end
  end

  assign o_spi_sclk   = sclk_r;
  assign o_spi_mosi   = sh_r[7];
  assign o_spi_cs_n   = cs_n_r;
  assign o_busy       = busy_r;
  assign o_frame_drop = drop_r;
  assign o_frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_bl_zone_spi_tx.sv
// Randomized self-checking bench for bl_zone_spi_tx. A queue-based model tracks
// captured zones per frame and the expected byte stream; an SPI monitor rebuilds
// each frame from the wire.
module tb_bl_zone_spi_tx;
  import bl_pkg::*;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, mosi, cs_n, busy, drop;
  logic [15:0] fcnt;

  bl_zone_spi_tx_if zif ();

  bl_zone_spi_tx #(.CLK_DIV(CLK_DIV)) dut (
    .i_pix_clk    (clk),
    .rst          (rst),
    .zin          (zif),
    .o_spi_sclk   (sclk),
    .o_spi_mosi   (mosi),
    .o_spi_cs_n   (cs_n),
    .o_busy       (busy),
    .o_frame_drop (drop),
    .o_frame_cnt  (fcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI monitor ----------------
  logic [7:0] rx_q[$];
  logic [7:0] frame_q[$];
  int         frames_done = 0;
  int         frame_len   = 0;

  initial begin
    int       low_cyc = 0;
    int       nb = 0;
    logic [7:0] acc = 8'h00;
    logic     cs_prev = 1'b1;
    logic     sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!cs_n && cs_prev) begin
        rx_q.delete();
        low_cyc = 0;
        nb = 0;
        acc = 8'h00;
      end
      if (!cs_n) begin
        low_cyc++;
        if (sclk && !sclk_prev) begin
          acc = {acc[6:0], mosi};
          nb++;
          if (nb == 8) begin
            rx_q.push_back(acc);
            nb = 0;
          end
        end
      end
      if (cs_n && !cs_prev) begin
        frame_q = rx_q;
        frame_len = low_cyc;
        frames_done++;
      end
      cs_prev = cs_n;
      sclk_prev = sclk;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] cap[$];
  logic [7:0] pend[$];
  int         model_cnt = 0;
  bit         model_busy = 1'b0;
  int         target = 0;

  // Bit-serial CRC-8 (poly 0x07) over the data bytes.
  function automatic logic [7:0] ref_crc(input logic [7:0] d[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (d[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ d[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic strobe(input logic [7:0] v, input int hold);
    zif.flag_done = 1'b1;
    zif.buf_360_flatted = v;
    repeat (hold) @(negedge clk);
    zif.flag_done = 1'b0;
    @(negedge clk);
    if (cap.size() < ZONES) cap.push_back(v);
  endtask

  task automatic vsync(input bit with_strobe, input logic [7:0] v);
    logic exp_drop;
    exp_drop = !(cap.size() == ZONES && !model_busy);
    if (!exp_drop) begin
      pend = cap;
      model_busy = 1'b1;
      target = frames_done + 1;
    end
    cap.delete();
    zif.r_Vsync_0 = 1'b1;
    if (with_strobe) begin
      zif.flag_done = 1'b1;
      zif.buf_360_flatted = v;
      cap.push_back(v);
    end
    @(negedge clk);
    chk_eq("frame_drop", drop, exp_drop);
    zif.r_Vsync_0 = 1'b0;
    zif.flag_done = 1'b0;
    @(negedge clk);
    chk_eq("drop_pulse_end", drop, 1'b0);
  endtask

  task automatic finish_frame(input string tag);
    int         n = 0;
    int         bad = 0;
    logic [7:0] e[$];
    while (frames_done < target && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_done"}, frames_done >= target, 1'b1);
    model_busy = 1'b0;
    model_cnt++;
    e.push_back(HEADER);
    foreach (pend[i]) e.push_back(pend[i]);
`ifdef BL_CRC8_EN
    e.push_back(ref_crc(pend));
`endif
    foreach (e[i]) begin
      if (i >= frame_q.size() || frame_q[i] !== e[i]) bad++;
    end
    chk_eq({tag, "_nbytes"}, frame_q.size(), e.size());
    chk_eq({tag, "_hdr"}, frame_q[0], HEADER);
    chk_eq({tag, "_bad_bytes"}, bad, 0);
    chk_eq({tag, "_cs_low_cycles"}, frame_len, e.size() * 16 * CLK_DIV + CLK_DIV);
    chk_eq({tag, "_frame_cnt"}, fcnt, model_cnt);
    chk_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    zif.flag_done = 1'b0;
    zif.buf_360_flatted = 8'h00;
    zif.r_Vsync_0 = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_sclk", sclk, 1'b0);
    chk_eq("rst_mosi", mosi, 1'b0);
    chk_eq("rst_cs_n", cs_n, 1'b1);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_drop", drop, 1'b0);
    chk_eq("rst_cnt", fcnt, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // No bank has ever been filled: a vsync must drop, not send.
    vsync(1'b0, 8'h00);
    repeat (20) @(negedge clk);
    chk_eq("empty_cs_n", cs_n, 1'b1);

    // T1: full frame of idx values.
    for (int i = 0; i < ZONES; i++) strobe(8'(i), 1);
    vsync(1'b0, 8'h00);
    chk_eq("t1_busy", busy, 1'b1);
    chk_eq("t1_cs_n", cs_n, 1'b0);
    finish_frame("t1");

    // T2: short frame is dropped and nothing goes out.
    for (int i = 0; i < ZONES - 1; i++) strobe(8'($urandom), 1);
    vsync(1'b0, 8'h00);
    repeat (30) @(negedge clk);
    chk_eq("t2_cs_n", cs_n, 1'b1);
    chk_eq("t2_cnt", fcnt, 16'd1);

    // T4: strobes held 5 cycles, plus surplus strobes beyond ZONES that must be ignored.
    for (int i = 0; i < ZONES + 4; i++) strobe((i < ZONES) ? 8'(i) : 8'($urandom), 5);
    vsync(1'b0, 8'h00);
    finish_frame("t4");

    // T5: reset while data byte 100 is on the wire.
    for (int i = 0; i < ZONES; i++) strobe(8'($urandom), 1);
    vsync(1'b0, 8'h00);
    n = 0;
    while (rx_q.size() < 101 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("t5_reach_byte100", rx_q.size() >= 101, 1'b1);
    rst = 1'b1;
    #1;
    chk_eq("t5_cs_n", cs_n, 1'b1);
    chk_eq("t5_busy", busy, 1'b0);
    chk_eq("t5_sclk", sclk, 1'b0);
    chk_eq("t5_cnt", fcnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    cap.delete();
    model_busy = 1'b0;
    model_cnt = 0;
    @(negedge clk);

    // T3: frame A in flight, overrun vsync coinciding with the first strobe of frame C.
    for (int i = 0; i < ZONES; i++) strobe(8'($urandom), int'($urandom_range(1, 3)));
    vsync(1'b0, 8'h00);
    repeat (50) @(negedge clk);
    chk_eq("t3_busy", busy, 1'b1);
    for (int i = 0; i < 100; i++) strobe(8'($urandom), 1);
    vsync(1'b1, 8'($urandom));
    for (int i = 0; i < ZONES - 1; i++) strobe(8'($urandom), 1);
    finish_frame("t3_cur");
    vsync(1'b0, 8'h00);
    finish_frame("t3_next");

`ifdef BL_CRC8_EN
    // T6: all-zero frame carries a zero CRC.
    for (int i = 0; i < ZONES; i++) strobe(8'h00, 1);
    vsync(1'b0, 8'h00);
    finish_frame("t6_zero");
    chk_eq("t6_zero_crc", frame_q[frame_q.size() - 1], 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
